mux_2x1: RTL and testbench

// - 2-to-1 data selector: combinational output Y = SEL ? B : A, plus an optional registered copy.
// - Combinational path is a zero-latency datapath steering element, e.g. feeding an ALU operand or a bypass path.
// - Registered path (Y_q/Y_vld) gives a timing-clean output for downstream synchronous logic.

---
 rtl/mux_2x1_pkg.sv | 11 +
 rtl/mux_2x1_cell.sv | 11 +
 rtl/mux_2x1.sv | 59 +++++
 tb/tb_mux_2x1.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mux_2x1_pkg.sv
// Shared definitions for the 2:1 data selector: default width and select encoding.
package mux_2x1_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_2x1_cell.sv
// Single-bit combinational 2:1 selector; an X/Z select propagates X through the ternary.
module mux_2x1_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_2x1.sv
// 2-to-1 data selector: zero-latency combinational output Y plus a registered copy
// (Y_q/SEL_q/Y_vld) captured on clk when EN is high.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int unsigned       WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SEL,
  input  logic             EN,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             Y_vld,
  output logic             SEL_q
);

  if (WIDTH < 1) begin : g_bad_width
    $error("mux_2x1: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_q;
  logic             r_y_vld;

  // Combinational path is independent of clk, rst_n and EN so it works with no clock at all.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    mux_2x1_cell u_cell (
      .i_a  (A[g]),
      .i_b  (B[g]),
      .i_sel(SEL),
      .o_y  (w_y[g])
    );
  end

  assign Y = w_y;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q   <= RST_VAL;
      r_sel_q <= SEL_A;
      r_y_vld <= 1'b0;
    end else if (EN) begin
      r_y_q   <= SEL ? B : A;
      r_sel_q <= SEL;
      r_y_vld <= 1'b1;
    end
  end

  assign Y_q   = r_y_q;
  assign SEL_q = r_sel_q;
  assign Y_vld = r_y_vld;

endmodule

// File: tb/tb_mux_2x1.sv
// Directed self-checking bench for mux_2x1: combinational select, async reset, capture/hold, random sweep.
module tb_mux_2x1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         sel, en;
  logic [W-1:0] y, y_q;
  logic         y_vld, sel_q;

  int n_cmp = 0;
  int n_bad = 0;

  mux_2x1 #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a),
    .B    (b),
    .SEL  (sel),
    .EN   (en),
    .Y    (y),
    .Y_q  (y_q),
    .Y_vld(y_vld),
    .SEL_q(sel_q)
  );

  // Clock stays idle until the bench enables it, so the first checks see an untoggled clk.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] eq, input logic evld,
                            input logic esel);
    check({tag, ".y_q"},   32'(y_q),   32'(eq));
    check({tag, ".y_vld"}, 32'(y_vld), 32'(evld));
    check({tag, ".sel_q"}, 32'(sel_q), 32'(esel));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1-2: combinational select with clk and rst_n never touched
    a = 8'h55; b = 8'hAA; sel = 1'b0;
    #1 check("comb_sel0", 32'(y), 32'h55);
    sel = 1'b1;
    #1 check("comb_sel1", 32'(y), 32'hAA);
    sel = 1'b0;
    #1 check("comb_back", 32'(y), 32'h55);

    // 3: asynchronous reset with clock running, asserted away from an edge
    en = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_regs("rst_async", 8'h00, 1'b0, 1'b0);
    check("rst_y", 32'(y), 32'h55);
    sel = 1'b1;
    #1 check("rst_y_follow", 32'(y), 32'hAA);
    @(posedge clk);
    #1 check_regs("rst_held", 8'h00, 1'b0, 1'b0);

    // 4: capture with EN=1
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; a = 8'h0F; b = 8'hF0; sel = 1'b1;
    @(posedge clk);
    #1 check_regs("cap_b", 8'hF0, 1'b1, 1'b1);
    @(negedge clk);
    sel = 1'b0;
    @(posedge clk);
    #1 check_regs("cap_a", 8'h0F, 1'b1, 1'b0);

    // 5: EN=0 holds registers while Y keeps tracking
    @(negedge clk);
    en = 1'b0; a = 8'h3C; b = 8'hC3; sel = 1'b1;
    #1 check("hold_y0", 32'(y), 32'hC3);
    @(posedge clk);
    #1 check_regs("hold0", 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'h81; b = 8'h7E; sel = 1'b0;
    #1 check("hold_y1", 32'(y), 32'h81);
    @(posedge clk);
    #1 check_regs("hold1", 8'h0F, 1'b1, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; sel = 1'b1;
    @(posedge clk);
    #1 check_regs("hold2", 8'h0F, 1'b1, 1'b0);
    check("hold_y2", 32'(y), 32'h01);

    // Same-cycle change of A, B and SEL: the edge samples the final values
    @(negedge clk);
    en = 1'b1; a = 8'h12; b = 8'h34; sel = 1'b0;
    #1 a = 8'hA5; b = 8'h5A; sel = 1'b1;
    @(posedge clk);
    #1 check_regs("cap_last", 8'h5A, 1'b1, 1'b1);

    // 6: reset pulse between edges clears registers immediately
    @(negedge clk);
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_regs("rst_pulse", 8'h00, 1'b0, 1'b0);
    check("rst_pulse_y", 32'(y), 32'h5A);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check_regs("post_rst_en0", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b1; a = 8'hE7; b = 8'h18; sel = 1'b0;
    @(posedge clk);
    #1 check_regs("post_rst_cap", 8'hE7, 1'b1, 1'b0);

    // Random sweep of the combinational path
    clk_run = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(1, 0));
      a = ra; b = rb; sel = rs;
      #1 check("rand_y", 32'(y), 32'(rs ? rb : ra));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
